// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
// Shares one single-port framebuffer RAM between VGA scanout reads and a
// pixel writer. Scanout always wins; the writer gets free cycles through a
// req/ack handshake. Read data comes back as a registered pixel stream with
// a fixed 3-clock latency from the sampled pixel tick.
module vga_fb_arbiter #(
  parameter int COL_BITS = 10,
  parameter int ROW_BITS = 9,
  parameter int DATA_W   = 8,
  parameter int STALL_W  = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clock_enable,
  input  logic                         pixel_valid,
  input  logic [9:0]                   vga_row,
  input  logic [9:0]                   vga_col,
  input  logic                         blank_only,
  input  logic                         wr_req,
  input  logic [ROW_BITS+COL_BITS-1:0] wr_addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic                         wr_ack,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [ROW_BITS+COL_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [DATA_W-1:0]            pixel_data,
  output logic                         pixel_out_valid,
  input  logic                         stall_clear,
  output logic [STALL_W-1:0]           wr_stall_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   rd_pending;
  logic   stall_cycle;

  // Row/column bits above the address fields are dropped on purpose; this
  // reduction keeps the whole timing bus visibly consumed.
  logic   unused_timing_bits;
  assign unused_timing_bits = ^{vga_row, vga_col};

  // State register; reset parks the arbiter with the RAM port idle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state arbitration: a qualified pixel tick always reads; otherwise a
  // pending write is taken unless we just wrote (absorbs the requester's
  // late deassert) or blank_only restricts writes to blanking.
  always_comb begin
    state_nxt   = IDLE;
    stall_cycle = 1'b0;
    if (clock_enable && pixel_valid) begin
      state_nxt = RD;
    end else if (wr_req && (state != WR) && (!blank_only || !pixel_valid)) begin
      state_nxt = WR;
    end
    if (wr_req && (state_nxt != WR) && (state != WR)) begin
      stall_cycle = 1'b1;
    end
  end

  // RAM control strobes follow the registered state directly.
  assign mem_en = (state != IDLE);
  assign mem_we = (state == WR);
  assign wr_ack = (state == WR);

  // Address/data registers load only when a new access is launched and
  // otherwise hold, so the RAM port stays quiet between accesses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state_nxt)
        RD: begin
          mem_addr <= {vga_row[ROW_BITS-1:0], vga_col[COL_BITS-1:0]};
        end
        WR: begin
          mem_addr  <= wr_addr;
          mem_wdata <= wr_data;
        end
        default: begin
        end
      endcase
    end
  end

  // Read return pipe: flag the read while it is on the RAM port, capture the
  // RAM output one clock later. Independent of the FSM so writes can follow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_pending      <= 1'b0;
      pixel_out_valid <= 1'b0;
      pixel_data      <= '0;
    end else begin
      rd_pending      <= (state == RD);
      pixel_out_valid <= rd_pending;
      if (rd_pending) begin
        pixel_data <= mem_rdata;
      end
    end
  end

  // Saturating count of cycles the writer was kept waiting.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_stall_count <= '0;
    end else if (stall_clear) begin
      wr_stall_count <= '0;
    end else if (stall_cycle && (wr_stall_count != '1)) begin
      wr_stall_count <= wr_stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
// Directed scenarios plus randomized traffic, all compared against a
// transaction-level model of the arbiter and a behavioural RAM.
module tb_vga_fb_arbiter;

  localparam int COL_BITS = 10;
  localparam int ROW_BITS = 9;
  localparam int DATA_W   = 8;
  localparam int STALL_W  = 16;
  localparam int AW       = ROW_BITS + COL_BITS;
  localparam int CNT_MAX  = (1 << STALL_W) - 1;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              clock_enable = 1'b0;
  logic              pixel_valid = 1'b0;
  logic [9:0]        vga_row = '0;
  logic [9:0]        vga_col = '0;
  logic              blank_only = 1'b0;
  logic              wr_req = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ack;
  logic              mem_en;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_out_valid;
  logic              stall_clear = 1'b0;
  logic [STALL_W-1:0] wr_stall_count;

  int total = 0;
  int bad = 0;

  vga_fb_arbiter #(
    .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .DATA_W(DATA_W), .STALL_W(STALL_W)
  ) dut (
    .clock(clock), .reset(reset), .clock_enable(clock_enable),
    .pixel_valid(pixel_valid), .vga_row(vga_row), .vga_col(vga_col),
    .blank_only(blank_only), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .pixel_data(pixel_data), .pixel_out_valid(pixel_out_valid),
    .stall_clear(stall_clear), .wr_stall_count(wr_stall_count)
  );

  // 100 MHz system clock.
  always #5 clock = ~clock;

  // Background content for never-written RAM locations.
  function automatic logic [DATA_W-1:0] ram_default(input int a);
    logic [31:0] v;
    v = a;
    return v[7:0] ^ v[15:8] ^ 8'h5A;
  endfunction

  // Behavioural single-port RAM with one clock of read latency.
  logic [DATA_W-1:0] ram [int];
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[int'(mem_addr)] = mem_wdata;
      end else begin
        mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : ram_default(int'(mem_addr));
      end
    end
  end

  // Reference model state: what the RAM port and pixel stream should show.
  typedef struct {
    int               due;
    logic [DATA_W-1:0] data;
  } pend_t;

  pend_t             m_q[$];
  logic [DATA_W-1:0] m_mem [int];
  int                n_edge = 0;
  bit                m_last_wr;
  bit                m_en, m_we, m_ack, m_pv;
  logic [AW-1:0]     m_addr;
  logic [DATA_W-1:0] m_wdata, m_pix;
  int                m_count;
  bit                full_check = 1'b1;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic preload(input int a, input logic [DATA_W-1:0] d);
    ram[a] = d;
    m_mem[a] = d;
  endtask

  function automatic logic [DATA_W-1:0] mem_lookup(input int a);
    return m_mem.exists(a) ? m_mem[a] : ram_default(a);
  endfunction

  task automatic model_reset();
    m_last_wr = 0; m_en = 0; m_we = 0; m_ack = 0; m_pv = 0;
    m_addr = '0; m_wdata = '0; m_pix = '0; m_count = 0;
    m_q.delete();
  endtask

  // Advance the model across one clock edge using the inputs now applied.
  task automatic model_step();
    bit rd, wr;
    int a;
    pend_t p;
    n_edge++;
    rd = clock_enable && pixel_valid;
    wr = !rd && wr_req && !m_last_wr && (!blank_only || !pixel_valid);
    if (stall_clear) m_count = 0;
    else if (wr_req && !wr && !m_last_wr && m_count < CNT_MAX) m_count++;
    if (rd) begin
      a = (int'(vga_row) % (1 << ROW_BITS)) * (1 << COL_BITS) + int'(vga_col);
      m_addr = a[AW-1:0];
      p.due = n_edge + 2;
      p.data = mem_lookup(a);
      m_q.push_back(p);
    end
    if (wr) begin
      m_addr = wr_addr;
      m_wdata = wr_data;
      m_mem[int'(wr_addr)] = wr_data;
    end
    m_en = rd || wr;
    m_we = wr;
    m_ack = wr;
    m_last_wr = wr;
    m_pv = 0;
    if (m_q.size() > 0 && m_q[0].due == n_edge) begin
      m_pix = m_q[0].data;
      m_pv = 1;
      void'(m_q.pop_front());
    end
  endtask

  task automatic check_all();
    check_output("mem_en", 32'(mem_en), 32'(m_en));
    check_output("mem_we", 32'(mem_we), 32'(m_we));
    check_output("wr_ack", 32'(wr_ack), 32'(m_ack));
    check_output("mem_addr", 32'(mem_addr), 32'(m_addr));
    check_output("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check_output("pix_valid", 32'(pixel_out_valid), 32'(m_pv));
    check_output("pix_data", 32'(pixel_data), 32'(m_pix));
    check_output("stall_cnt", 32'(wr_stall_count), 32'(m_count));
  endtask

  // One clock: model the coming edge, then sample 1 ns after it.
  task automatic tick_cycle();
    if (!reset) model_reset();
    else model_step();
    @(posedge clock);
    #1;
    if (full_check) check_all();
  endtask

  bit pending_drop = 0;
  bit prev_ce = 0;

  task automatic apply_stimulus();
    clock_enable = !prev_ce && ($urandom_range(0, 2) == 0);
    prev_ce = clock_enable;
    pixel_valid = ($urandom_range(0, 3) != 0);
    vga_row = 10'($urandom_range(0, 3) | ($urandom_range(0, 1) << 9));
    vga_col = 10'($urandom_range(0, 7));
    stall_clear = ($urandom_range(0, 49) == 0);
    if (pending_drop) begin
      wr_req = 0;
      pending_drop = 0;
    end else if (m_ack) begin
      pending_drop = 1;
    end else if (!wr_req && $urandom_range(0, 2) == 0) begin
      wr_req = 1;
      wr_addr = AW'(($urandom_range(0, 3) << COL_BITS) | $urandom_range(0, 7));
      wr_data = DATA_W'($urandom);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #5ms;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) tick_cycle();
    reset = 1'b1;

    // Reset asserted while a read is in flight.
    preload((1 << COL_BITS) | 2, 8'h77);
    clock_enable = 1; pixel_valid = 1; vga_row = 10'd1; vga_col = 10'd2;
    tick_cycle();
    check_output("t1_rd_issued", 32'(mem_en), 32'd1);
    clock_enable = 0;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_output("t1_rst_en", 32'(mem_en), 32'd0);
    check_output("t1_rst_addr", 32'(mem_addr), 32'd0);
    check_output("t1_rst_pix", 32'(pixel_data), 32'd0);
    repeat (3) begin
      tick_cycle();
      check_output("t1_no_valid", 32'(pixel_out_valid), 32'd0);
    end
    reset = 1'b1;
    clock_enable = 1;
    tick_cycle();
    clock_enable = 0;
    repeat (2) tick_cycle();
    check_output("t1_after_pix", 32'(pixel_data), 32'h77);
    check_output("t1_after_val", 32'(pixel_out_valid), 32'd1);

    // Basic scanout read with 3-clock latency.
    preload((5 << COL_BITS) | 7, 8'hA5);
    clock_enable = 1; pixel_valid = 1; vga_row = 10'd5; vga_col = 10'd7;
    tick_cycle();
    check_output("t2_addr", 32'(mem_addr), 32'((5 << 10) | 7));
    check_output("t2_we", 32'(mem_we), 32'd0);
    clock_enable = 0;
    tick_cycle();
    check_output("t2_early", 32'(pixel_out_valid), 32'd0);
    tick_cycle();
    check_output("t2_pix", 32'(pixel_data), 32'hA5);
    check_output("t2_val", 32'(pixel_out_valid), 32'd1);
    tick_cycle();
    check_output("t2_pulse", 32'(pixel_out_valid), 32'd0);

    // Single write in idle time; requester drops one clock after ack.
    pixel_valid = 0;
    wr_req = 1; wr_addr = 19'h00123; wr_data = 8'h3C;
    tick_cycle();
    check_output("t3_ack", 32'(wr_ack), 32'd1);
    check_output("t3_we", 32'(mem_we), 32'd1);
    check_output("t3_addr", 32'(mem_addr), 32'h123);
    check_output("t3_wdata", 32'(mem_wdata), 32'h3C);
    tick_cycle();
    check_output("t3_no_regrant", 32'(wr_ack), 32'd0);
    wr_req = 0;
    repeat (3) begin
      tick_cycle();
      check_output("t3_single", 32'(wr_ack), 32'd0);
    end
    check_output("t3_cnt", 32'(wr_stall_count), 32'd0);
    clock_enable = 1; pixel_valid = 1; vga_row = 10'd0; vga_col = 10'h123;
    tick_cycle();
    clock_enable = 0;
    repeat (2) tick_cycle();
    check_output("t3_readback", 32'(pixel_data), 32'h3C);

    // Read and write collide; read wins, write follows.
    clock_enable = 1; pixel_valid = 1; vga_row = 10'd2; vga_col = 10'd3;
    wr_req = 1; wr_addr = 19'h00456; wr_data = 8'h99;
    tick_cycle();
    check_output("t4_read_wins", 32'(mem_we), 32'd0);
    check_output("t4_no_ack", 32'(wr_ack), 32'd0);
    clock_enable = 0;
    tick_cycle();
    check_output("t4_ack", 32'(wr_ack), 32'd1);
    tick_cycle();
    wr_req = 0;
    check_output("t4_cnt", 32'(wr_stall_count), 32'd1);

    // blank_only keeps the writer out during active video.
    stall_clear = 1;
    tick_cycle();
    stall_clear = 0;
    blank_only = 1; pixel_valid = 1; wr_req = 1; wr_addr = 19'h00789; wr_data = 8'h42;
    for (int i = 0; i < 20; i++) begin
      clock_enable = (i % 4 == 0);
      tick_cycle();
      check_output("t5_blocked", 32'(wr_ack), 32'd0);
    end
    check_output("t5_cnt", 32'(wr_stall_count), 32'd20);
    clock_enable = 0; pixel_valid = 0;
    tick_cycle();
    check_output("t5_grant", 32'(wr_ack), 32'd1);
    tick_cycle();
    wr_req = 0;
    repeat (3) tick_cycle();

    // Stall counter saturation and clear.
    full_check = 0;
    pixel_valid = 1; wr_req = 1; wr_addr = 19'h00001; wr_data = 8'h11;
    repeat ((1 << STALL_W) + 5) tick_cycle();
    check_output("t6_sat", 32'(wr_stall_count), 32'(CNT_MAX));
    check_output("t6_sat_model", 32'(wr_stall_count), 32'(m_count));
    stall_clear = 1;
    tick_cycle();
    check_output("t6_clear", 32'(wr_stall_count), 32'd0);
    stall_clear = 0; wr_req = 0; pixel_valid = 0; blank_only = 0;
    tick_cycle();
    full_check = 1;
    tick_cycle();

    // Randomized traffic against the model.
    pending_drop = 0;
    prev_ce = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 250 == 0) blank_only = ($urandom_range(0, 1) == 1);
      apply_stimulus();
      tick_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
